xip_line_buffer: RTL

XIP_LINE_BUFFER -- requirements
Module: xip_line_buffer

---
 rtl/xip_line_buffer_if.sv | 32 +++
 rtl/xip_line_buffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/xip_line_buffer_if.sv
// Bundles the CPU-side AHB slave port and the flash-side AHB master port of the XIP line buffer.
// The slave modport is the buffer's view; the master modport is the view of whatever drives it.
interface xip_line_buffer_if;
  logic        HSEL;
  logic [35:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA;
  logic        INV;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic        M_HSEL;
  logic [35:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic [2:0]  M_HSIZE;
  logic [2:0]  M_HBURST;
  logic        M_HWRITE;
  logic        M_HREADY;
  logic [63:0] M_HRDATA;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, INV, M_HREADY, M_HRDATA,
    output HREADY, HRESP, HRDATA, M_HSEL, M_HADDR, M_HTRANS, M_HSIZE, M_HBURST, M_HWRITE
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, INV, M_HREADY, M_HRDATA,
    input  HREADY, HRESP, HRDATA, M_HSEL, M_HADDR, M_HTRANS, M_HSIZE, M_HBURST, M_HWRITE
  );
endinterface

// File: rtl/xip_line_buffer.sv
// Single-line read buffer for execute-in-place flash: zero-wait hits, INCR4 line fill on a miss.
// state  | meaning
// IDLE   | no transfer in data phase, ready for a new address phase
// DPHASE | data phase of an accepted transfer: write ignored, hit served, miss starts fill
// FILL   | INCR4 burst to flash; addresses and data phases overlap
// RESP   | line just filled, serve the waiting read
module xip_line_buffer #(
  parameter int LINE_BEATS = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  xip_line_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, DPHASE, FILL, RESP} state_t;

  state_t           state;
  logic [35:3]      addr_q;
  logic             write_q;
  logic             valid;
  logic             pending;
  logic [30:0]      tag;
  logic [CNT_W-1:0] addr_cnt;
  logic [CNT_W-1:0] data_cnt;
  logic             addr_done;
  logic             data_act;
  logic [63:0]      line_data [LINE_BEATS];
  logic             hit;
  logic             ready;
  logic             accept;
  logic             capture;

  wire logic unused_bits = ^{bus.HWDATA, bus.HSIZE, bus.HTRANS[0], bus.HADDR[2:0]};

  assign hit     = valid && (tag == addr_q[35:5]);
  assign accept  = bus.HSEL && bus.HTRANS[1] && ready;
  assign capture = (state == FILL) && bus.M_HREADY && data_act;

  always_comb begin
    ready = 1'b1;
    case (state)
      DPHASE:  ready = write_q || hit;
      FILL:    ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      valid     <= 1'b0;
      pending   <= 1'b0;
      tag       <= '0;
      addr_cnt  <= '0;
      data_cnt  <= '0;
      addr_done <= 1'b0;
      data_act  <= 1'b0;
    end else begin
      if (bus.INV && state != FILL) valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.HADDR[35:3];
            write_q <= bus.HWRITE;
            state   <= DPHASE;
          end
        end
        DPHASE: begin
          if (!write_q && !hit) begin
            valid     <= 1'b0;
            pending   <= 1'b0;
            addr_cnt  <= '0;
            data_cnt  <= '0;
            addr_done <= 1'b0;
            data_act  <= 1'b0;
            state     <= FILL;
          end else if (accept) begin
            addr_q  <= bus.HADDR[35:3];
            write_q <= bus.HWRITE;
          end else begin
            state <= IDLE;
          end
        end
        FILL: begin
          if (bus.INV) pending <= 1'b1;
          if (bus.M_HREADY) begin
            // an address accepted now has its data phase in the next cycle
            data_act <= !addr_done;
            if (!addr_done) begin
              addr_cnt <= addr_cnt + 1'b1;
              if (addr_cnt == LAST) addr_done <= 1'b1;
            end
            if (data_act) begin
              data_cnt <= data_cnt + 1'b1;
              if (data_cnt == LAST) begin
                tag     <= addr_q[35:5];
                valid   <= !(pending || bus.INV);
                pending <= 1'b0;
                state   <= RESP;
              end
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (capture) line_data[data_cnt] <= bus.M_HRDATA;
  end

  assign bus.HREADY   = ready;
  assign bus.HRESP    = 1'b0;
  assign bus.HRDATA   = ((state == DPHASE && !write_q && hit) || state == RESP)
                        ? line_data[addr_q[4:3]] : '0;
  assign bus.M_HSEL   = (state == FILL);
  assign bus.M_HTRANS = (state == FILL && !addr_done)
                        ? ((addr_cnt == '0) ? 2'b10 : 2'b11) : 2'b00;
  assign bus.M_HADDR  = (state == FILL) ? {addr_q[35:5], addr_cnt, 3'b000} : '0;
  assign bus.M_HSIZE  = 3'b011;
  assign bus.M_HBURST = 3'b011;
  assign bus.M_HWRITE = 1'b0;
endmodule
